led_count_display: RTL and testbench
====================================

// Module: led_count_display
// PURPOSE
//   Downstream display stage for the debounced push-button LED counter.
//   Takes the counter's 10-bit binary value (0..1023) and converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine.
//   Drives four active-low 7-segment digits (HEX3..HEX0) so the count is readable in decimal.
//   Converts only when the input value changes; the display holds the last converted value while a conversion runs.
// PARAMETERS
//   BLANK_LEADING  1  1: blank leading zero digits (HEX0 never blanked); 0: show all four digits
// PORTS
//   clk      input   1   system clock; all state changes on posedge
//   rst_n    input   1   asynchronous, active-low reset
//   value    input   10  binary count from the counter stage; unsigned, any cycle
//   busy     output  1   high while a conversion is in progress
//   update   output  1   one-cycle pulse; bcd/hex* took a new value on this edge
//   bcd      output  16  {thousands,hundreds,tens,ones}; 4 bits per digit
//   hex0     output  7   ones digit, {g,f,e,d,c,b,a}, active-low
//   hex1     output  7   tens digit, same encoding
//   hex2     output  7   hundreds digit, same encoding
//   hex3     output  7   thousands digit, same encoding
// BEHAVIOUR
//   Reset (async assert, sync-to-clk release):
//     - state=IDLE, last_value=0, bcd=0, busy=0, update=0
//     - hex0=7'b1000000 ("0")
//     - hex1..hex3=7'b1111111 if BLANK_LEADING=1, else 7'b1000000
//   Segment patterns, digits 0..9:
//     1000000 1111001 0100100 0110000 0011001 0010010 0000010 1111000 0000000 0010000
//   FSM, two states:
//     IDLE:
//       - busy=0
//       - On a posedge with value!=last_value: last_value<=value, shift_reg(26b)<={16'b0,value}, cnt<=0, state<=CONV
//       - Otherwise hold
//     CONV:
//       - busy=1
//       - Each edge: in the BCD field, add 3 to every nibble >=5, then shift the whole 26-bit register left by 1; cnt<=cnt+1
//       - On the edge where cnt==9 (the 10th CONV edge):
//         - bcd<=final BCD field, registered hex0..3 updated from it
//         - update<=1 for exactly one cycle
//         - state<=IDLE
//   Latency: change-detect edge E -> bcd/hex/update valid after edge E+10; busy high from E through E+9.
//   Throughput: back-to-back conversions possible; the next detect occurs earliest at E+11.
//   value changes during CONV are ignored; the first IDLE edge compares against last_value and reconverts if different.
//     Intermediate values may be skipped.
//   Arithmetic: adjust+shift done combinationally in the same cycle; nibbles never exceed 9 after adjust.
//     1023 -> 16'h1023 fits with no overflow.
//   Blanking (BLANK_LEADING=1): digit k (k=1..3) is 7'b1111111 iff digit k and all higher digits are 0.
//   Reset mid-CONV: conversion aborted, outputs return to reset values, no update pulse.
//     After release, value!=0 triggers a fresh conversion.
//   hex* and bcd change only on update edges or reset; never glitch mid-conversion.
// TESTING
//   1. Reset asserted, then released with value=0:
//      -> hex0=1000000, hex1..3=1111111, bcd=0, busy=0, no update pulse for 50 cycles.
//   2. value 0->1023 at edge E:
//      -> busy=1 over E..E+9, update pulse at E+10, bcd=16'h1023,
//         hex3=1111001, hex2=1000000, hex1=0100100, hex0=0110000.
//   3. value=105, BLANK_LEADING=1:
//      -> bcd=16'h0105, hex3=1111111, hex2=1111001, hex1=1000000, hex0=0010010.
//      Same with BLANK_LEADING=0 -> hex3=1000000.
//   4. value 8, then 9 on the 3rd CONV cycle:
//      -> first update shows bcd=16'h0008, second conversion starts next IDLE edge, second update shows 16'h0009.
//   5. rst_n low during the 5th CONV cycle (converting 512):
//      -> outputs immediately at reset values, no update.
//      After release, conversion reruns and gives bcd=16'h0512.
//   6. Sweep value 0..1023, waiting for update each time:
//      -> bcd matches a decimal model; exactly one update per distinct value; no update while value is steady.

Source files
------------

// File: rtl/led_count_display.sv
// ============================================================================
// Module   : led_count_display
// Purpose  : Sequential double-dabble binary-to-BCD converter that drives four
//            active-low 7-segment digits, with optional leading-zero blanking.
// Revision : 1.0
// ============================================================================
`default_nettype none

module led_count_display #(
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  value,
    output logic        busy,
    output logic        update,
    output logic [15:0] bcd,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_t;

    localparam logic [6:0] C_SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] C_SEG_BLANK = 7'b1111111;
    localparam logic [6:0] C_UPPER_RST = BLANK_LEADING ? C_SEG_BLANK : C_SEG_ZERO;
    localparam logic [3:0] C_LAST_CNT  = 4'd9;

    function automatic logic [6:0] seg7(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = C_SEG_BLANK;
        endcase
        return seg;
    endfunction

    state_t      state_q,      state_d;
    logic [9:0]  last_value_q, last_value_d;
    logic [25:0] shift_q,      shift_d;
    logic [3:0]  cnt_q,        cnt_d;
    logic [15:0] bcd_q,        bcd_d;
    logic [6:0]  hex0_q,       hex0_d;
    logic [6:0]  hex1_q,       hex1_d;
    logic [6:0]  hex2_q,       hex2_d;
    logic [6:0]  hex3_q,       hex3_d;
    logic        busy_q,       busy_d;
    logic        update_q,     update_d;

    logic [25:0] w_shift_adj;
    logic [25:0] w_shift_nxt;
    logic [15:0] w_bcd_final;

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift.
    always_comb begin
        w_shift_adj = shift_q;
        for (int i = 0; i < 4; i++) begin
            if (shift_q[10 + 4*i +: 4] >= 4'd5) begin
                w_shift_adj[10 + 4*i +: 4] = shift_q[10 + 4*i +: 4] + 4'd3;
            end
        end
        w_shift_nxt = w_shift_adj << 1;
        w_bcd_final = w_shift_nxt[25:10];
    end

    always_comb begin
        state_d      = state_q;
        last_value_d = last_value_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        bcd_d        = bcd_q;
        hex0_d       = hex0_q;
        hex1_d       = hex1_q;
        hex2_d       = hex2_q;
        hex3_d       = hex3_q;
        busy_d       = busy_q;
        update_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (value != last_value_q) begin
                    last_value_d = value;
                    shift_d      = {16'b0, value};
                    cnt_d        = 4'd0;
                    state_d      = S_CONV;
                    busy_d       = 1'b1;
                end
            end
            S_CONV: begin
                shift_d = w_shift_nxt;
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == C_LAST_CNT) begin
                    bcd_d    = w_bcd_final;
                    hex0_d   = seg7(w_bcd_final[3:0]);
                    // A digit blanks only when it and every higher digit are zero.
                    hex1_d   = (BLANK_LEADING && (w_bcd_final[15:4] == 12'd0))
                               ? C_SEG_BLANK : seg7(w_bcd_final[7:4]);
                    hex2_d   = (BLANK_LEADING && (w_bcd_final[15:8] == 8'd0))
                               ? C_SEG_BLANK : seg7(w_bcd_final[11:8]);
                    hex3_d   = (BLANK_LEADING && (w_bcd_final[15:12] == 4'd0))
                               ? C_SEG_BLANK : seg7(w_bcd_final[15:12]);
                    update_d = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_value_q <= 10'd0;
            shift_q      <= 26'd0;
            cnt_q        <= 4'd0;
            bcd_q        <= 16'd0;
            hex0_q       <= C_SEG_ZERO;
            hex1_q       <= C_UPPER_RST;
            hex2_q       <= C_UPPER_RST;
            hex3_q       <= C_UPPER_RST;
            busy_q       <= 1'b0;
            update_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_value_q <= last_value_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            bcd_q        <= bcd_d;
            hex0_q       <= hex0_d;
            hex1_q       <= hex1_d;
            hex2_q       <= hex2_d;
            hex3_q       <= hex3_d;
            busy_q       <= busy_d;
            update_q     <= update_d;
        end
    end

    assign busy   = busy_q;
    assign update = update_q;
    assign bcd    = bcd_q;
    assign hex0   = hex0_q;
    assign hex1   = hex1_q;
    assign hex2   = hex2_q;
    assign hex3   = hex3_q;

endmodule

`default_nettype wire

// File: tb/tb_led_count_display.sv
// ============================================================================
// Module   : tb_led_count_display
// Purpose  : Scoreboard bench for led_count_display, both blanking variants.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_led_count_display;

    typedef struct {
        logic [9:0] val;
        int         exp_cyc;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  value = 10'd0;

    logic        busy, update, busy_b0, update_b0;
    logic [15:0] bcd, bcd_b0;
    logic [6:0]  hex0, hex1, hex2, hex3;
    logic [6:0]  hex0_b0, hex1_b0, hex2_b0, hex3_b0;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          disp = 0;
    logic [9:0]  last_drv = 10'd0;
    item_t       sb[$];

    logic [6:0]  seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                   7'b0000000, 7'b0010000};
    int          p10 [0:3] = '{1, 10, 100, 1000};

    led_count_display #(.BLANK_LEADING(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .busy(busy), .update(update),
        .bcd(bcd), .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3)
    );

    led_count_display #(.BLANK_LEADING(1'b0)) dut_b0 (
        .clk(clk), .rst_n(rst_n), .value(value), .busy(busy_b0), .update(update_b0),
        .bcd(bcd_b0), .hex0(hex0_b0), .hex1(hex1_b0), .hex2(hex2_b0), .hex3(hex3_b0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cyc=%0d disp=%0d", name, act, exp, cyc, disp);
        end
    endtask

    function automatic logic [15:0] model_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Expected {hex3,hex2,hex1,hex0} from the decimal value itself.
    function automatic logic [27:0] model_hex(input int v, input bit blank);
        logic [27:0] r;
        for (int k = 0; k < 4; k++) begin
            if (blank && k > 0 && v < p10[k]) r[7*k +: 7] = 7'b1111111;
            else                              r[7*k +: 7] = seg_tab[(v / p10[k]) % 10];
        end
        return r;
    endfunction

    // Monitor: busy window, update timing and held display value every cycle.
    always @(negedge clk) begin
        logic  exp_busy;
        item_t it;
        exp_busy = (sb.size() > 0) && (cyc >= sb[0].exp_cyc - 10) && (cyc < sb[0].exp_cyc);
        chk("busy", {31'd0, busy}, {31'd0, exp_busy});
        chk("busy_noblank", {31'd0, busy_b0}, {31'd0, exp_busy});
        chk("update_noblank", {31'd0, update_b0}, {31'd0, update});
        if (update) begin
            if (sb.size() == 0) begin
                chk("spurious_update", 32'd1, 32'd0);
            end else begin
                it = sb.pop_front();
                chk("update_cycle", cyc, it.exp_cyc);
                disp = int'(it.val);
            end
        end else if (sb.size() > 0 && cyc >= sb[0].exp_cyc) begin
            chk("missing_update", 32'd0, 32'd1);
            it = sb.pop_front();
            disp = int'(it.val);
        end
        chk("bcd", {16'd0, bcd}, {16'd0, model_bcd(disp)});
        chk("bcd_noblank", {16'd0, bcd_b0}, {16'd0, model_bcd(disp)});
        chk("hex_blank", {4'd0, hex3, hex2, hex1, hex0}, {4'd0, model_hex(disp, 1'b1)});
        chk("hex_noblank", {4'd0, hex3_b0, hex2_b0, hex1_b0, hex0_b0}, {4'd0, model_hex(disp, 1'b0)});
    end

    task automatic issue(input logic [9:0] v);
        @(negedge clk);
        value = v;
        if (v != last_drv) sb.push_back('{v, cyc + 11});
        last_drv = v;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            chk("idle_timeout", 32'd0, 32'd1);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        logic [9:0] v;

        // Reset, then a quiet period with value held at zero.
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (50) @(negedge clk);

        issue(10'd1023);
        wait_idle();
        issue(10'd105);
        wait_idle();

        // Change during conversion: second value picked up right after the first.
        issue(10'd8);
        k = cyc;
        repeat (2) @(negedge clk);
        value = 10'd9;
        sb.push_back('{10'd9, k + 22});
        last_drv = 10'd9;
        wait_idle();

        // Reset in the middle of a conversion aborts it; release reconverts.
        issue(10'd512);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        disp = 0;
        last_drv = 10'd0;
        #1;
        chk("rst_async_bcd", {16'd0, bcd}, 32'd0);
        chk("rst_async_busy", {31'd0, busy}, 32'd0);
        chk("rst_async_update", {31'd0, update}, 32'd0);
        chk("rst_async_hex", {4'd0, hex3, hex2, hex1, hex0}, {4'd0, model_hex(0, 1'b1)});
        chk("rst_async_hex_nb", {4'd0, hex3_b0, hex2_b0, hex1_b0, hex0_b0}, {4'd0, model_hex(0, 1'b0)});
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        sb.push_back('{10'd512, cyc + 11});
        last_drv = 10'd512;
        wait_idle();

        for (int i = 0; i < 1024; i++) begin
            issue(10'(i));
            wait_idle();
        end

        for (int n = 0; n < 200; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            v = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 7) == 0) v = last_drv;
            issue(v);
            wait_idle();
        end

        repeat (20) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
